// File: rtl/palette_pixel_fifo_if.sv
// palette_pixel_fifo_if: controller, lookup, pixel and status signals of the palette pixel FIFO
interface palette_pixel_fifo_if #(
    parameter int LAYERS = 32,
    parameter int COLORS = 32,
    parameter int DEPTH = 16,
    parameter int COORD_W = 11
) ();
    logic writeEn;
    logic [$clog2(LAYERS)-1:0] controllerLayer;
    logic [$clog2(COLORS)-1:0] controllerColor;
    logic controllerRGB;
    logic [15:0] controllerWriteData;
    logic [15:0] controllerReadData;
    logic pipeValid;
    logic [$clog2(LAYERS)-1:0] pipeLayer;
    logic [$clog2(COLORS)-1:0] pipeColor;
    logic [COORD_W-1:0] xPosition;
    logic [COORD_W-1:0] yPosition;
    logic pixelReq;
    logic [23:0] pixelData;
    logic pixelValid;
    logic [$clog2(DEPTH+1)-1:0] fifoCount;
    logic fifoFull;
    logic fifoEmpty;
    logic overflow;
    logic underflow;
    logic clearFlags;
    modport master (
        output writeEn, controllerLayer, controllerColor, controllerRGB, controllerWriteData,
        output pipeValid, pipeLayer, pipeColor, xPosition, yPosition, pixelReq, clearFlags,
        input controllerReadData, pixelData, pixelValid, fifoCount, fifoFull, fifoEmpty, overflow, underflow
    );
    modport slave (
        input writeEn, controllerLayer, controllerColor, controllerRGB, controllerWriteData,
        input pipeValid, pipeLayer, pipeColor, xPosition, yPosition, pixelReq, clearFlags,
        output controllerReadData, pixelData, pixelValid, fifoCount, fifoFull, fifoEmpty, overflow, underflow
    );
endinterface

// File: rtl/palette_pixel_fifo.sv
// palette_pixel_fifo: two-stage palette lookup feeding a pixel FIFO; define PALETTE_PIXEL_DEDUP_EN to drop repeated (x,y) pushes
module palette_pixel_fifo #(
    parameter int LAYERS = 32,
    parameter int COLORS = 32,
    parameter int DEPTH = 16,
    parameter int COORD_W = 11
) (
    input logic clk_pipe,
    input logic rst,
    palette_pixel_fifo_if.slave bus
);
    localparam int LW = $clog2(LAYERS);
    localparam int CLW = $clog2(COLORS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [23:0] pal_q [2**(LW+CLW)];
    logic [23:0] mem_q [DEPTH];
    logic [LW+CLW-1:0] caddr, paddr;
    logic [23:0] s1_rgb_q, pix_q;
    logic [15:0] rd_q;
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic s1_v_q, pv_q, ovf_q, unf_q, ovf_d, unf_d;
    logic full, empty, dup, push_try, push, pop;
    assign caddr = {bus.controllerLayer, bus.controllerColor};
    assign paddr = {bus.pipeLayer, bus.pipeColor};
    assign full = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign push_try = s1_v_q & ~dup;
    assign push = push_try & ~full;
    assign pop = bus.pixelReq & ~empty;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);
    assign ovf_d = (push_try & full) | (ovf_q & ~bus.clearFlags);
    assign unf_d = (bus.pixelReq & empty) | (unf_q & ~bus.clearFlags);
    assign bus.controllerReadData = rd_q;
    assign bus.pixelData = pix_q;
    assign bus.pixelValid = pv_q;
    assign bus.fifoCount = cnt_q;
    assign bus.fifoFull = full;
    assign bus.fifoEmpty = empty;
    assign bus.overflow = ovf_q;
    assign bus.underflow = unf_q;
    // Unreset storage: palette halves, lookup data and FIFO slots
    always_ff @(posedge clk_pipe) begin
        if (bus.writeEn && !bus.controllerRGB) pal_q[caddr][23:8] <= bus.controllerWriteData;
        if (bus.writeEn && bus.controllerRGB) pal_q[caddr][7:0] <= bus.controllerWriteData[7:0];
        if (bus.pipeValid) s1_rgb_q <= pal_q[paddr];
        if (push) mem_q[wp_q] <= s1_rgb_q;
    end
    // Readback, lookup valid, FIFO pointers/count, sticky flags and pixel output
    always_ff @(posedge clk_pipe or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
            s1_v_q <= 1'b0;
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            pix_q <= '0;
            pv_q <= 1'b0;
        end else begin
            rd_q <= bus.controllerRGB ? {8'h00, pal_q[caddr][7:0]} : pal_q[caddr][23:8];
            s1_v_q <= bus.pipeValid & (bus.pipeColor != '0);
            wp_q <= wp_q + AW'(push);
            rp_q <= rp_q + AW'(pop);
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            pv_q <= pop;
            if (bus.pixelReq) pix_q <= pop ? mem_q[rp_q] : 24'h000000;
        end
    end
`ifdef PALETTE_PIXEL_DEDUP_EN
    logic [COORD_W-1:0] s1_x_q, s1_y_q, last_x_q, last_y_q;
    logic last_v_q;
    assign dup = last_v_q && s1_x_q == last_x_q && s1_y_q == last_y_q;
    // Lookup coordinates and the coordinates of the most recent accepted push
    always_ff @(posedge clk_pipe or posedge rst) begin
        if (rst) begin
            s1_x_q <= '0;
            s1_y_q <= '0;
            last_x_q <= '0;
            last_y_q <= '0;
            last_v_q <= 1'b0;
        end else begin
            if (bus.pipeValid) begin
                s1_x_q <= bus.xPosition;
                s1_y_q <= bus.yPosition;
            end
            if (push) begin
                last_v_q <= 1'b1;
                last_x_q <= s1_x_q;
                last_y_q <= s1_y_q;
            end
        end
    end
`else
    logic unused_xy;
    assign unused_xy = ^{bus.xPosition, bus.yPosition};
    assign dup = 1'b0;
`endif
endmodule

// File: tb/tb_palette_pixel_fifo.sv
// tb_palette_pixel_fifo: directed and random checks against a queue-based model, pops checked by a scoreboard monitor
module tb_palette_pixel_fifo;
    localparam int LAYERS = 32;
    localparam int COLORS = 32;
    localparam int DEPTH = 16;
    localparam int COORD_W = 11;
    localparam int LW = $clog2(LAYERS);
    localparam int CLW = $clog2(COLORS);
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    palette_pixel_fifo_if #(.LAYERS(LAYERS), .COLORS(COLORS), .DEPTH(DEPTH), .COORD_W(COORD_W)) bif ();
    palette_pixel_fifo #(.LAYERS(LAYERS), .COLORS(COLORS), .DEPTH(DEPTH), .COORD_W(COORD_W)) dut (
        .clk_pipe(clk),
        .rst(rst),
        .bus(bif)
    );
    int total = 0;
    int bad = 0;
    logic [23:0] pal_m [LAYERS][COLORS];
    logic [23:0] fifo_m [$];
    logic [23:0] exp_pix [$];
    bit s1_v, last_v, ovf, unf, empty_pop;
    logic [23:0] s1_rgb;
    int s1_x, s1_y, last_x, last_y;
    logic [15:0] exp_rd;
`ifdef PALETTE_PIXEL_DEDUP_EN
    bit dedup = 1'b1;
`else
    bit dedup = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(bif.fifoCount), 32'(fifo_m.size()));
        chk("full", 32'(bif.fifoFull), 32'(fifo_m.size() == DEPTH));
        chk("empty", 32'(bif.fifoEmpty), 32'(fifo_m.size() == 0));
        chk("overflow", 32'(bif.overflow), 32'(ovf));
        chk("underflow", 32'(bif.underflow), 32'(unf));
        chk("readdata", 32'(bif.controllerReadData), 32'(exp_rd));
        if (empty_pop) begin
            chk("empty_pop_data", 32'(bif.pixelData), 32'd0);
            chk("empty_pop_valid", 32'(bif.pixelValid), 32'd0);
        end
    endtask

    task automatic model_reset();
        fifo_m.delete();
        s1_v = 0;
        last_v = 0;
        ovf = 0;
        unf = 0;
        empty_pop = 0;
        exp_rd = '0;
    endtask

    // One clock: check the previous edge, drive inputs, advance the model across the next edge
    task automatic cyc(input bit we, input int wl, input int wc, input bit rgb, input int wd,
                       input bit pv, input int pl, input int pc, input int x, input int y,
                       input bit req, input bit clr);
        bit full_b, dup, ovf_set, unf_set;
        check_state();
        bif.writeEn = we;
        bif.controllerLayer = LW'(wl);
        bif.controllerColor = CLW'(wc);
        bif.controllerRGB = rgb;
        bif.controllerWriteData = 16'(wd);
        bif.pipeValid = pv;
        bif.pipeLayer = LW'(pl);
        bif.pipeColor = CLW'(pc);
        bif.xPosition = COORD_W'(x);
        bif.yPosition = COORD_W'(y);
        bif.pixelReq = req;
        bif.clearFlags = clr;
        full_b = fifo_m.size() == DEPTH;
        ovf_set = 0;
        unf_set = 0;
        empty_pop = 0;
        if (req) begin
            if (fifo_m.size() > 0) exp_pix.push_back(fifo_m.pop_front());
            else begin
                unf_set = 1;
                empty_pop = 1;
            end
        end
        if (s1_v) begin
            dup = dedup && last_v && s1_x == last_x && s1_y == last_y;
            if (!dup) begin
                if (full_b) ovf_set = 1;
                else begin
                    fifo_m.push_back(s1_rgb);
                    last_v = 1;
                    last_x = s1_x;
                    last_y = s1_y;
                end
            end
        end
        ovf = ovf_set || (ovf && !clr);
        unf = unf_set || (unf && !clr);
        exp_rd = rgb ? {8'h00, pal_m[wl][wc][7:0]} : pal_m[wl][wc][23:8];
        s1_v = pv && pc != 0;
        if (pv) begin
            s1_rgb = pal_m[pl][pc];
            s1_x = x % (1 << COORD_W);
            s1_y = y % (1 << COORD_W);
        end
        if (we && !rgb) pal_m[wl][wc][23:8] = 16'(wd);
        if (we && rgb) pal_m[wl][wc][7:0] = 8'(wd);
        @(negedge clk);
    endtask

    task automatic wr(input int l, input int c, input bit rgb, input int d);
        cyc(1, l, c, rgb, d, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic rd(input int l, input int c, input bit rgb);
        cyc(0, l, c, rgb, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic look(input int l, input int c, input int x, input int y);
        cyc(0, 0, 0, 0, 0, 1, l, c, x, y, 0, 0);
    endtask
    task automatic pop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask
    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic drain();
        idle();
        idle();
        while (fifo_m.size() > 0) pop();
        idle();
    endtask

    // Scoreboard monitor: every presented pixel must match the oldest expected pop
    initial forever begin
        @(negedge clk);
        if (bif.pixelValid === 1'b1) begin
            if (exp_pix.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %0h expected no pixel", bif.pixelData);
            end else chk("pop_data", 32'(bif.pixelData), 32'(exp_pix.pop_front()));
        end
    end

    initial begin
        {bif.writeEn, bif.controllerLayer, bif.controllerColor, bif.controllerRGB, bif.controllerWriteData} = '0;
        {bif.pipeValid, bif.pipeLayer, bif.pipeColor, bif.xPosition, bif.yPosition} = '0;
        {bif.pixelReq, bif.clearFlags} = '0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_count", 32'(bif.fifoCount), 32'd0);
        chk("rst_empty", 32'(bif.fifoEmpty), 32'd1);
        chk("rst_full", 32'(bif.fifoFull), 32'd0);
        chk("rst_flags", 32'({bif.overflow, bif.underflow}), 32'd0);
        chk("rst_pixel", 32'({bif.pixelValid, bif.pixelData}), 32'd0);
        chk("rst_readdata", 32'(bif.controllerReadData), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int l = 0; l < LAYERS; l++)
            for (int c = 0; c < COLORS; c++) begin
                wr(l, c, 0, int'($urandom_range(0, 65535)));
                wr(l, c, 1, int'($urandom_range(0, 255)));
            end
        wr(2, 5, 0, 16'hA1B2);
        wr(2, 5, 1, 16'h00C3);
        rd(2, 5, 0);
        chk("readback_rg", 32'(bif.controllerReadData), 32'h0000A1B2);
        rd(2, 5, 1);
        chk("readback_b", 32'(bif.controllerReadData), 32'h000000C3);
        look(2, 5, 10, 20);
        chk("count_after_1_edge", 32'(bif.fifoCount), 32'd0);
        idle();
        chk("count_after_2_edges", 32'(bif.fifoCount), 32'd1);
        pop();
        chk("pop_pixel", 32'(bif.pixelData), 32'h00A1B2C3);
        chk("pop_valid", 32'(bif.pixelValid), 32'd1);
        idle();
        chk("valid_one_cycle", 32'(bif.pixelValid), 32'd0);
        look(0, 3, 11, 21);
        look(1, 3, 11, 21);
        idle();
        idle();
        chk("dedup_count", 32'(bif.fifoCount), dedup ? 32'd1 : 32'd2);
        drain();
        for (int i = 0; i <= DEPTH; i++) look(3, 1 + i, 100 + i, 50);
        idle();
        idle();
        chk("fill_full", 32'(bif.fifoFull), 32'd1);
        chk("fill_overflow", 32'(bif.overflow), 32'd1);
        chk("fill_count", 32'(bif.fifoCount), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) pop();
        idle();
        chk("drained_empty", 32'(bif.fifoEmpty), 32'd1);
        pop();
        chk("underflow_data", 32'(bif.pixelData), 32'd0);
        chk("underflow_valid", 32'(bif.pixelValid), 32'd0);
        chk("underflow_set", 32'(bif.underflow), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("underflow_cleared", 32'(bif.underflow), 32'd0);
        for (int i = 0; i < 5; i++) look(4, 1 + i, 200 + i, 7);
        idle();
        idle();
        chk("queued_five", 32'(bif.fifoCount), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(bif.fifoCount), 32'd0);
        chk("async_rst_empty", 32'(bif.fifoEmpty), 32'd1);
        chk("async_rst_full", 32'(bif.fifoFull), 32'd0);
        chk("async_rst_flags", 32'({bif.overflow, bif.underflow}), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rd(2, 5, 0);
        chk("palette_kept", 32'(bif.controllerReadData), 32'h0000A1B2);
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 7) == 0, int'($urandom_range(0, LAYERS - 1)), int'($urandom_range(0, COLORS - 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                $urandom_range(0, 9) < 7, int'($urandom_range(0, LAYERS - 1)),
                $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(1, COLORS - 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom_range(0, 99) < (((i / 250) % 2 == 1) ? 70 : 20), $urandom_range(0, 15) == 0);
        drain();
        idle();
        chk("pending_pops", 32'(exp_pix.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
